// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - backend types shared by decode and the cosim retire path
`define BP_COSIM_RETIRE_WIDTH(vaddr_mp, instr_mp, dword_mp, reg_mp) \
  ((vaddr_mp) + (instr_mp) + (reg_mp) + 2*(dword_mp) + 3)

package bp_be_pkg;

  localparam int vaddr_width_gp    = 39;
  localparam int instr_width_gp    = 32;
  localparam int dword_width_gp    = 64;
  localparam int reg_addr_width_gp = 5;

  typedef struct packed {
    logic [6:0]                   opcode;
    logic [reg_addr_width_gp-1:0] rd_addr;
    logic [2:0]                   fu_op;
    logic                         irf_w_v;
  } bp_be_decode_s;

  typedef struct packed {
    logic [vaddr_width_gp-1:0]    pc;
    logic [instr_width_gp-1:0]    instr;
    logic                         rd_w_v;
    logic [reg_addr_width_gp-1:0] rd_addr;
    logic [dword_width_gp-1:0]    data;
    logic                         data_v;
    logic                         interrupt;
    logic [dword_width_gp-1:0]    cause;
  } bp_cosim_retire_s;

  typedef logic [`BP_COSIM_RETIRE_WIDTH(vaddr_width_gp, instr_width_gp,
                  dword_width_gp, reg_addr_width_gp)-1:0] bp_cosim_retire_flat_t;

endpackage

// File: rtl/bp_nonsynth_oldest_match.sv
// rtl/bp_nonsynth_oldest_match.sv - oldest-first one-hot select over a circular buffer
module bp_nonsynth_oldest_match #(
  parameter int els_p = 8,
  localparam int idx_w_lp = $clog2(els_p)
) (
  input  logic [els_p-1:0]    match_i,
  input  logic [idx_w_lp-1:0] head_i,
  output logic [els_p-1:0]    oldest_o,
  output logic                found_o
);

  logic [els_p-1:0] w_rot;
  logic [els_p-1:0] w_prio;
  logic             w_hit;

  // Rotate so the head sits at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    w_rot    = '0;
    w_prio   = '0;
    oldest_o = '0;
    w_hit    = 1'b0;
    for (int i = 0; i < els_p; i++) begin
      w_rot[i] = match_i[idx_w_lp'(i) + head_i];
    end
    for (int i = 0; i < els_p; i++) begin
      if (w_rot[i] && !w_hit) begin
        w_prio[i] = 1'b1;
        w_hit     = 1'b1;
      end
    end
    for (int i = 0; i < els_p; i++) begin
      oldest_o[idx_w_lp'(i) + head_i] = w_prio[i];
    end
  end

  assign found_o = |match_i;

endmodule

// File: rtl/bp_nonsynth_commit_aligner.sv
// rtl/bp_nonsynth_commit_aligner.sv - pairs in-order commits with late rd writeback for cosim
module bp_nonsynth_commit_aligner
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p    = vaddr_width_gp,
  parameter int instr_width_p    = instr_width_gp,
  parameter int dword_width_p    = dword_width_gp,
  parameter int reg_addr_width_p = reg_addr_width_gp,
  parameter int els_p            = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        commit_v_i,
  input  logic [vaddr_width_p-1:0]    commit_pc_i,
  input  logic [instr_width_p-1:0]    commit_instr_i,
  input  logic                        commit_rd_w_v_i,
  input  logic [reg_addr_width_p-1:0] commit_rd_addr_i,
  input  logic                        commit_rd_late_i,
  input  logic [dword_width_p-1:0]    commit_rd_data_i,
  input  logic                        interrupt_v_i,
  input  logic [dword_width_p-1:0]    cause_i,
  input  logic                        late_w_v_i,
  input  logic [reg_addr_width_p-1:0] late_w_addr_i,
  input  logic [dword_width_p-1:0]    late_w_data_i,
  output logic                        retire_v_o,
  input  logic                        retire_yumi_i,
  output logic [vaddr_width_p-1:0]    retire_pc_o,
  output logic [instr_width_p-1:0]    retire_instr_o,
  output logic                        retire_rd_w_v_o,
  output logic [reg_addr_width_p-1:0] retire_rd_addr_o,
  output logic [dword_width_p-1:0]    retire_rd_data_o,
  output logic                        retire_interrupt_o,
  output logic [dword_width_p-1:0]    retire_cause_o,
  output logic                        empty_o,
  output logic                        overflow_o,
  output logic                        protocol_err_o
);

  localparam int idx_w_lp = $clog2(els_p);
  localparam int ptr_w_lp = idx_w_lp + 1;

  bp_cosim_retire_s      r_mem [els_p];
  logic [els_p-1:0]      r_valid;
  logic [ptr_w_lp-1:0]   r_head;
  logic [ptr_w_lp-1:0]   r_tail;
  logic                  r_overflow;
  logic                  r_protocol_err;

  logic [idx_w_lp-1:0]   w_head_idx;
  logic [idx_w_lp-1:0]   w_tail_idx;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_retire_v;
  logic                  w_yumi_ok;
  logic                  w_yumi_bad;
  logic                  w_enq_req;
  logic                  w_enq;
  logic                  w_drop;
  logic                  w_both;
  logic                  w_rd_w_v;
  logic                  w_late_miss;
  logic                  w_found;
  logic [els_p-1:0]      w_match;
  logic [els_p-1:0]      w_oldest;
  bp_cosim_retire_s      w_enq_rec;
  bp_cosim_retire_s      w_head_rec;

  assign w_head_idx = r_head[idx_w_lp-1:0];
  assign w_tail_idx = r_tail[idx_w_lp-1:0];
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[idx_w_lp] != r_tail[idx_w_lp]);
  assign w_head_rec = r_mem[w_head_idx];

  assign w_retire_v = ~w_empty & w_head_rec.data_v;
  assign w_yumi_ok  = retire_yumi_i & w_retire_v;
  assign w_yumi_bad = retire_yumi_i & ~w_retire_v;

  // A trap wins over a simultaneous commit; only one record is ever enqueued per cycle.
  assign w_both    = commit_v_i & interrupt_v_i;
  assign w_enq_req = commit_v_i | interrupt_v_i;
  assign w_enq     = w_enq_req & (~w_full | w_yumi_ok);
  assign w_drop    = w_enq_req & w_full & ~w_yumi_ok;

  always_comb begin
    w_rd_w_v            = commit_v_i & ~interrupt_v_i & commit_rd_w_v_i
                        & (commit_rd_addr_i != '0);
    w_enq_rec           = '0;
    w_enq_rec.pc        = commit_pc_i;
    w_enq_rec.instr     = commit_instr_i;
    w_enq_rec.interrupt = interrupt_v_i;
    w_enq_rec.cause     = interrupt_v_i ? cause_i : '0;
    w_enq_rec.rd_w_v    = w_rd_w_v;
    w_enq_rec.rd_addr   = interrupt_v_i ? '0 : commit_rd_addr_i;
    w_enq_rec.data_v    = ~w_rd_w_v | ~commit_rd_late_i;
    w_enq_rec.data      = (w_rd_w_v & ~commit_rd_late_i) ? commit_rd_data_i : '0;
  end

  // Only registered entries are candidates, so a same-cycle enqueue can never catch a late write.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < els_p; i++) begin
      w_match[i] = late_w_v_i & r_valid[i] & r_mem[i].rd_w_v & ~r_mem[i].data_v
                 & (r_mem[i].rd_addr == late_w_addr_i);
    end
  end

  bp_nonsynth_oldest_match #(
    .els_p(els_p)
  ) u_oldest_match (
    .match_i  (w_match),
    .head_i   (w_head_idx),
    .oldest_o (w_oldest),
    .found_o  (w_found)
  );

  assign w_late_miss = late_w_v_i & ~w_found;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_valid        <= '0;
      r_overflow     <= 1'b0;
      r_protocol_err <= 1'b0;
      for (int i = 0; i < els_p; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_protocol_err <= w_both | w_yumi_bad | w_late_miss;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_yumi_ok) begin
        r_valid[w_head_idx]       <= 1'b0;
        r_mem[w_head_idx].data_v  <= 1'b0;
        r_head                    <= r_head + ptr_w_lp'(1);
      end
      for (int i = 0; i < els_p; i++) begin
        if (w_oldest[i]) begin
          r_mem[i].data   <= late_w_data_i;
          r_mem[i].data_v <= 1'b1;
        end
      end
      // Enqueue last: when full with a same-cycle yumi the tail slot is the one just freed.
      if (w_enq) begin
        r_valid[w_tail_idx] <= 1'b1;
        r_mem[w_tail_idx]   <= w_enq_rec;
        r_tail              <= r_tail + ptr_w_lp'(1);
      end
    end
  end

  assign retire_v_o         = w_retire_v;
  assign retire_pc_o        = w_head_rec.pc;
  assign retire_instr_o     = w_head_rec.instr;
  assign retire_rd_w_v_o    = w_head_rec.rd_w_v;
  assign retire_rd_addr_o   = w_head_rec.rd_addr;
  assign retire_rd_data_o   = w_head_rec.data;
  assign retire_interrupt_o = w_head_rec.interrupt;
  assign retire_cause_o     = w_head_rec.cause;
  assign empty_o            = w_empty;
  assign overflow_o         = r_overflow;
  assign protocol_err_o     = r_protocol_err;

endmodule

// File: tb/tb_bp_nonsynth_commit_aligner.sv
// tb/tb_bp_nonsynth_commit_aligner.sv - scoreboard bench for the commit aligner
module tb_bp_nonsynth_commit_aligner;

  logic        clk_i;
  logic        reset_n_i;
  logic        commit_v_i;
  logic [38:0] commit_pc_i;
  logic [31:0] commit_instr_i;
  logic        commit_rd_w_v_i;
  logic [4:0]  commit_rd_addr_i;
  logic        commit_rd_late_i;
  logic [63:0] commit_rd_data_i;
  logic        interrupt_v_i;
  logic [63:0] cause_i;
  logic        late_w_v_i;
  logic [4:0]  late_w_addr_i;
  logic [63:0] late_w_data_i;
  logic        retire_v_o;
  logic        retire_yumi_i;
  logic [38:0] retire_pc_o;
  logic [31:0] retire_instr_o;
  logic        retire_rd_w_v_o;
  logic [4:0]  retire_rd_addr_o;
  logic [63:0] retire_rd_data_o;
  logic        retire_interrupt_o;
  logic [63:0] retire_cause_o;
  logic        empty_o;
  logic        overflow_o;
  logic        protocol_err_o;

  logic yumi_en;
  logic yumi_force;
  assign retire_yumi_i = yumi_force | (yumi_en & retire_v_o);

  bp_nonsynth_commit_aligner dut (
    .clk_i              (clk_i),
    .reset_n_i          (reset_n_i),
    .commit_v_i         (commit_v_i),
    .commit_pc_i        (commit_pc_i),
    .commit_instr_i     (commit_instr_i),
    .commit_rd_w_v_i    (commit_rd_w_v_i),
    .commit_rd_addr_i   (commit_rd_addr_i),
    .commit_rd_late_i   (commit_rd_late_i),
    .commit_rd_data_i   (commit_rd_data_i),
    .interrupt_v_i      (interrupt_v_i),
    .cause_i            (cause_i),
    .late_w_v_i         (late_w_v_i),
    .late_w_addr_i      (late_w_addr_i),
    .late_w_data_i      (late_w_data_i),
    .retire_v_o         (retire_v_o),
    .retire_yumi_i      (retire_yumi_i),
    .retire_pc_o        (retire_pc_o),
    .retire_instr_o     (retire_instr_o),
    .retire_rd_w_v_o    (retire_rd_w_v_o),
    .retire_rd_addr_o   (retire_rd_addr_o),
    .retire_rd_data_o   (retire_rd_data_o),
    .retire_interrupt_o (retire_interrupt_o),
    .retire_cause_o     (retire_cause_o),
    .empty_o            (empty_o),
    .overflow_o         (overflow_o),
    .protocol_err_o     (protocol_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [38:0] pc;
    logic [31:0] instr;
    logic        wv;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        intr;
    logic [63:0] cause;
  } exp_s;

  exp_s sb[$];
  exp_s mon_e;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk_i) begin
    if (reset_n_i && retire_v_o && retire_yumi_i) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_record: got pc 0x%0h expected no record", retire_pc_o);
      end else begin
        mon_e = sb.pop_front();
        check("rec_pc",    64'(retire_pc_o),      64'(mon_e.pc));
        check("rec_instr", 64'(retire_instr_o),   64'(mon_e.instr));
        check("rec_rd_w_v",64'(retire_rd_w_v_o),  64'(mon_e.wv));
        check("rec_rd_addr",64'(retire_rd_addr_o),64'(mon_e.addr));
        check("rec_data",  retire_rd_data_o,      mon_e.data);
        check("rec_intr",  64'(retire_interrupt_o),64'(mon_e.intr));
        check("rec_cause", retire_cause_o,        mon_e.cause);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_commit(input logic [38:0] pc, input logic wv, input logic [4:0] addr,
                           input logic late, input logic [63:0] data,
                           input logic [63:0] exp_data, input logic push);
    exp_s e;
    commit_v_i       = 1'b1;
    commit_pc_i      = pc;
    commit_instr_i   = 32'h0000_0013 ^ 32'(pc);
    commit_rd_w_v_i  = wv;
    commit_rd_addr_i = addr;
    commit_rd_late_i = late;
    commit_rd_data_i = data;
    e.pc = pc; e.instr = 32'h0000_0013 ^ 32'(pc); e.wv = wv && (addr != 5'd0);
    e.addr = addr; e.data = exp_data; e.intr = 1'b0; e.cause = 64'h0;
    if (push) sb.push_back(e);
    cyc();
    commit_v_i = 1'b0; commit_rd_w_v_i = 1'b0; commit_rd_late_i = 1'b0;
  endtask

  task automatic do_trap(input logic [38:0] pc, input logic [63:0] cause, input logic with_commit);
    exp_s e;
    interrupt_v_i    = 1'b1;
    cause_i          = cause;
    commit_v_i       = with_commit;
    commit_pc_i      = pc;
    commit_instr_i   = 32'h0000_0073;
    commit_rd_w_v_i  = with_commit;
    commit_rd_addr_i = 5'd3;
    commit_rd_data_i = 64'h55;
    e.pc = pc; e.instr = 32'h0000_0073; e.wv = 1'b0; e.addr = 5'd0;
    e.data = 64'h0; e.intr = 1'b1; e.cause = cause;
    sb.push_back(e);
    cyc();
    interrupt_v_i = 1'b0; commit_v_i = 1'b0; commit_rd_w_v_i = 1'b0;
  endtask

  task automatic do_late(input logic [4:0] addr, input logic [63:0] data);
    late_w_v_i    = 1'b1;
    late_w_addr_i = addr;
    late_w_data_i = data;
    cyc();
    late_w_v_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    cyc();
    cyc();
    reset_n_i = 1'b1;
    cyc();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) cyc();
    cyc();
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within budget");
    $fatal(1);
  end

  initial begin
    reset_n_i = 1'b0; commit_v_i = 1'b0; commit_pc_i = '0; commit_instr_i = '0;
    commit_rd_w_v_i = 1'b0; commit_rd_addr_i = '0; commit_rd_late_i = 1'b0;
    commit_rd_data_i = '0; interrupt_v_i = 1'b0; cause_i = '0; late_w_v_i = 1'b0;
    late_w_addr_i = '0; late_w_data_i = '0; yumi_en = 1'b1; yumi_force = 1'b0;
    do_reset();
    check("reset_retire_v", 64'(retire_v_o), 64'd0);
    check("reset_empty", 64'(empty_o), 64'd1);
    check("reset_overflow", 64'(overflow_o), 64'd0);
    check("reset_perr", 64'(protocol_err_o), 64'd0);

    // Three plain commits, checker always ready.
    do_commit(39'h80000000, 1'b0, 5'd0, 1'b0, 64'h0, 64'h0, 1'b1);
    check("lat1_retire_v", 64'(retire_v_o), 64'd1);
    check("lat1_pc", 64'(retire_pc_o), 64'h80000000);
    do_commit(39'h80000004, 1'b0, 5'd0, 1'b0, 64'h0, 64'h0, 1'b1);
    do_commit(39'h80000008, 1'b0, 5'd0, 1'b0, 64'h0, 64'h0, 1'b1);
    check("lat3_pc", 64'(retire_pc_o), 64'h80000008);
    cyc();
    check("t1_empty", 64'(empty_o), 64'd1);

    // Late write to x5 holds the head, then releases both in order.
    do_commit(39'h100, 1'b1, 5'd5, 1'b1, 64'h0, 64'hDEAD, 1'b1);
    do_commit(39'h104, 1'b0, 5'd0, 1'b0, 64'h0, 64'h0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      check("t2_blocked", 64'(retire_v_o), 64'd0);
      cyc();
    end
    late_w_v_i = 1'b1; late_w_addr_i = 5'd5; late_w_data_i = 64'hDEAD;
    check("t2_blocked_wcycle", 64'(retire_v_o), 64'd0);
    cyc();
    late_w_v_i = 1'b0;
    check("t2_release_v", 64'(retire_v_o), 64'd1);
    check("t2_release_data", retire_rd_data_o, 64'hDEAD);
    drain("t2_drain");

    // Two pending x7 writes fill oldest first; an unmatched x9 write is an error.
    do_commit(39'h200, 1'b1, 5'd7, 1'b1, 64'h0, 64'd1, 1'b1);
    do_commit(39'h204, 1'b1, 5'd7, 1'b1, 64'h0, 64'd2, 1'b1);
    do_late(5'd7, 64'd1);
    do_late(5'd7, 64'd2);
    check("t3_no_err", 64'(protocol_err_o), 64'd0);
    drain("t3_drain");
    do_late(5'd9, 64'h99);
    check("t3_err_pulse", 64'(protocol_err_o), 64'd1);
    cyc();
    check("t3_err_clear", 64'(protocol_err_o), 64'd0);
    // Early data path on a real writer, and x0 forced to a non-writer.
    do_commit(39'h280, 1'b1, 5'd4, 1'b0, 64'h1234, 64'h1234, 1'b1);
    do_commit(39'h284, 1'b1, 5'd0, 1'b1, 64'h777, 64'h0, 1'b1);
    drain("t3b_drain");

    // Overflow: ninth commit with no yumi is dropped.
    do_reset();
    yumi_en = 1'b0;
    for (int i = 0; i < 8; i++)
      do_commit(39'h300 + 39'(4*i), 1'b0, 5'd0, 1'b0, 64'h0, 64'h0, 1'b1);
    check("t4_not_empty", 64'(empty_o), 64'd0);
    check("t4_overflow_pre", 64'(overflow_o), 64'd0);
    do_commit(39'h320, 1'b0, 5'd0, 1'b0, 64'h0, 64'h0, 1'b0);
    check("t4_overflow", 64'(overflow_o), 64'd1);
    cyc(); cyc(); cyc();
    check("t4_overflow_sticky", 64'(overflow_o), 64'd1);
    yumi_en = 1'b1;
    drain("t4_drain");
    check("t4_overflow_after_drain", 64'(overflow_o), 64'd1);

    // Full with a same-cycle yumi accepts the ninth commit.
    do_reset();
    check("t4b_overflow_reset", 64'(overflow_o), 64'd0);
    yumi_en = 1'b0;
    for (int i = 0; i < 8; i++)
      do_commit(39'h400 + 39'(4*i), 1'b0, 5'd0, 1'b0, 64'h0, 64'h0, 1'b1);
    yumi_en = 1'b1;
    do_commit(39'h420, 1'b0, 5'd0, 1'b0, 64'h0, 64'h0, 1'b1);
    check("t4b_no_overflow", 64'(overflow_o), 64'd0);
    drain("t4b_drain");
    check("t4b_no_overflow_end", 64'(overflow_o), 64'd0);

    // Traps, and commit+trap together.
    do_trap(39'h600, 64'h8000000000000007, 1'b0);
    check("t5_intr", 64'(retire_interrupt_o), 64'd1);
    check("t5_cause", retire_cause_o, 64'h8000000000000007);
    check("t5_no_err", 64'(protocol_err_o), 64'd0);
    do_trap(39'h604, 64'h2, 1'b1);
    check("t5_both_err", 64'(protocol_err_o), 64'd1);
    drain("t5_drain");
    yumi_force = 1'b1;
    cyc();
    yumi_force = 1'b0;
    check("t5_bad_yumi_err", 64'(protocol_err_o), 64'd1);
    check("t5_bad_yumi_empty", 64'(empty_o), 64'd1);
    cyc();
    check("t5_err_clear", 64'(protocol_err_o), 64'd0);

    // Async reset with five entries held.
    yumi_en = 1'b0;
    for (int i = 0; i < 5; i++)
      do_commit(39'h700 + 39'(4*i), 1'b0, 5'd0, 1'b0, 64'h0, 64'h0, 1'b0);
    check("t6_held_v", 64'(retire_v_o), 64'd1);
    check("t6_held_empty", 64'(empty_o), 64'd0);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("t6_async_v", 64'(retire_v_o), 64'd0);
    check("t6_async_empty", 64'(empty_o), 64'd1);
    cyc();
    cyc();
    reset_n_i = 1'b1;
    yumi_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t6_no_stale", 64'(retire_v_o), 64'd0);
    end
    check("t6_empty_after", 64'(empty_o), 64'd1);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bp_nonsynth_commit_aligner.md
Name: bp_nonsynth_commit_aligner

Overview:
- Nonsynth monitor that sits directly upstream of the Dromajo cosim checker.
- Captures in-order commit and interrupt events from the backend.
- Pairs each committed instruction with its rd writeback data, which may arrive several cycles late from the long-latency pipe.
- Presents complete in-order retire records to the checker over a valid/yumi interface.

Parameters:
- vaddr_width_p, 39, committed PC width.
- instr_width_p, 32, instruction width.
- dword_width_p, 64, register data / cause width.
- reg_addr_width_p, 5, integer register address width.
- els_p, 8, retire buffer depth; must be a power of 2 and at least 2.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset. One clock; reset is asynchronous and active-low.
- commit_v_i  in  1  instruction committed this cycle.
- commit_pc_i  in  vaddr_width_p  committed PC.
- commit_instr_i  in  instr_width_p  committed instruction.
- commit_rd_w_v_i  in  1  instruction writes the integer rd.
- commit_rd_addr_i  in  reg_addr_width_p  rd address.
- commit_rd_late_i  in  1  rd data arrives later on the late_w port.
- commit_rd_data_i  in  dword_width_p  rd data; valid this cycle when not late.
- interrupt_v_i  in  1  trap/interrupt taken this cycle.
- cause_i  in  dword_width_p  decompressed cause.
- late_w_v_i  in  1  long-latency writeback.
- late_w_addr_i  in  reg_addr_width_p  writeback rd address.
- late_w_data_i  in  dword_width_p  writeback data.
- retire_v_o  out  1  head record complete.
- retire_yumi_i  in  1  checker consumes the head record.
- retire_pc_o  out  vaddr_width_p  head PC.
- retire_instr_o  out  instr_width_p  head instruction.
- retire_rd_w_v_o  out  1  head record writes rd.
- retire_rd_addr_o  out  reg_addr_width_p  head rd address.
- retire_rd_data_o  out  dword_width_p  head rd data.
- retire_interrupt_o  out  1  head record is a trap.
- retire_cause_o  out  dword_width_p  head cause.
- empty_o  out  1  no entries held.
- overflow_o  out  1  sticky: an event was dropped because the buffer was full.
- protocol_err_o  out  1  one-cycle pulse on an illegal input combination.

Behaviour:
- Reset (async assert, sync deassert): head/tail pointers=0, all entry valid/data_v=0, overflow_o=0, protocol_err_o=0, retire_v_o=0, empty_o=1.
- Storage: circular buffer of els_p entries. Head/tail pointers are clog2(els_p) bits plus one wrap bit.
  - full = indices equal and wrap bits differ.
  - empty = pointers equal.
- Enqueue on commit_v_i or interrupt_v_i.
  - Entry data_v = interrupt | ~rd_w_v | ~late.
  - Early data is captured from commit_rd_data_i.
- rd_addr==0 is forced to rd_w_v=0, data=0, data_v=1; late is ignored.
- Both commit_v_i and interrupt_v_i high: pulse protocol_err_o, enqueue the interrupt only.
- Full and enqueue without retire_yumi_i the same cycle: event dropped, overflow_o set until reset.
- Full with retire_yumi_i the same cycle: enqueue proceeds.
- Late write matching:
  - Writes the oldest entry (search from head) with rd_w_v=1, data_v=0, rd_addr==late_w_addr_i.
  - On a match: stores the data and sets data_v.
  - Matches only registered entries, never the entry being enqueued that same cycle.
  - No match: protocol_err_o pulses, write dropped.
- Output:
  - retire_v_o = ~empty & head.data_v.
  - retire_* fields are combinational from the head entry.
  - Head-of-line blocking is required: younger complete entries never bypass the head.
  - Latency from enqueue to retire_v_o is 1 cycle minimum (registered storage).
  - A late write into the head entry raises retire_v_o the next cycle.
- retire_yumi_i is legal only while retire_v_o=1. Otherwise it is ignored and protocol_err_o pulses.
- Pointer wrap: indices roll over at els_p and the wrap bit toggles.
- Reset mid-operation discards all entries with no partial output.

Decomposition:
- The retire record struct bp_cosim_retire_s (pc, instr, rd_w_v, rd_addr, data, data_v, interrupt, cause) and its width macro belong in bp_be_pkg next to the decode struct.
- One sub-module, bp_nonsynth_oldest_match:
  - Input: per-entry match vector and head index.
  - Output: one-hot oldest match and a found flag.
  - Implemented by rotating by head, priority-encoding, then rotating back.

Test Plan:
- Three commits, no rd writes, retire_yumi_i held 1 -> three records in order (PCs 0x80000000, 0x80000004, 0x80000008), each 1 cycle after its commit, empty_o=1 at the end.
- Commit of a late write to x5 at PC 0x100, then a non-write commit at PC 0x104; late_w x5=0xDEAD 4 cycles later -> retire_v_o=0 until the cycle after the late write, then PC 0x100 data 0xDEAD, then 0x104.
- Two pending late writes to x7; late_w x7=1 then x7=2 -> oldest entry gets 1, younger gets 2; late_w x9 with nothing pending -> protocol_err_o single pulse.
- Fill 8 entries with retire_yumi_i=0, then a 9th commit -> overflow_o=1 and stays 1; a 9th commit with yumi the same cycle from fresh reset -> accepted, no overflow.
- interrupt_v_i with cause 0x8000000000000007 -> retire_interrupt_o=1 with that cause; commit_v_i and interrupt_v_i together -> only the trap is enqueued, protocol_err_o pulses.
- Assert reset_n_i low mid-stream with 5 entries held -> retire_v_o drops to 0 immediately (async), empty_o=1, and no stale record appears after release.
